// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select add/sub: WIDTH splits into BLK-bit blocks, with a register stage every BPS blocks.
// One result per cycle; the whole pipe stalls together under output backpressure.
module pipelined_carry_select_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLK   = 4,
    parameter int unsigned BPS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned SW   = BLK * BPS;
    localparam int unsigned NSTG = WIDTH / SW;
    localparam int unsigned LAST = NSTG - 1;
    localparam int unsigned BW   = BLK + 1;

    if ((WIDTH % SW) != 0 || WIDTH < SW) begin : g_bad_params
        $error("pipelined_carry_select_adder: WIDTH must be a nonzero multiple of BLK*BPS");
    end

    logic             en;
    logic [WIDTH-1:0] a_in  [NSTG];
    logic [WIDTH-1:0] b_in  [NSTG];
    logic [WIDTH-1:0] s_in  [NSTG];
    logic             c_in  [NSTG];
    logic [WIDTH-1:0] s_nxt [NSTG];
    logic             c_nxt [NSTG];
    logic [WIDTH-1:0] a_q   [NSTG];
    logic [WIDTH-1:0] b_q   [NSTG];
    logic [WIDTH-1:0] s_q   [NSTG];
    logic             c_q   [NSTG];
    logic             v_q   [NSTG];
    logic             ovf_nxt;
    logic             ovf_q;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        logic [BPS:0]     cc;
        logic [SW-1:0]    ss;
        logic [WIDTH-1:0] sn;

        // Stage 0 consumes the prepared operands directly; later stages read the previous stage register.
        if (s == 0) begin : g_src
            assign a_in[s] = a;
            assign b_in[s] = sub ? ~b : b;
            assign c_in[s] = sub | cin;
            assign s_in[s] = '0;
        end else begin : g_src
            assign a_in[s] = a_q[s-1];
            assign b_in[s] = b_q[s-1];
            assign c_in[s] = c_q[s-1];
            assign s_in[s] = s_q[s-1];
        end

        assign cc[0] = c_in[s];

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            localparam int unsigned LO = s * SW + j * BLK;
            logic [BW-1:0] r0;
            logic [BW-1:0] r1;

            assign r0 = {1'b0, a_in[s][LO +: BLK]} + {1'b0, b_in[s][LO +: BLK]};

            // Lowest block of the word has no select pair: it ripples straight from the carry-in.
            if (LO == 0) begin : g_ripple
                assign r1 = r0 + BW'(cc[j]);
                assign {cc[j+1], ss[j*BLK +: BLK]} = r1;
            end else begin : g_select
                assign r1 = r0 + BW'(1);
                assign {cc[j+1], ss[j*BLK +: BLK]} = cc[j] ? r1 : r0;
            end
        end

        always_comb begin
            sn                = s_in[s];
            sn[s*SW +: SW]    = ss;
        end

        assign s_nxt[s] = sn;
        assign c_nxt[s] = cc[BPS];
    end

    assign ovf_nxt = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &
                     (s_nxt[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);

    // Pipeline registers; every stage advances together on en, bubbles included.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nxt[k];
                c_q[k] <= c_nxt[k];
            end
            v_q[0] <= in_valid;
            for (int unsigned k = 1; k < NSTG; k++) begin
                v_q[k] <= v_q[k-1];
            end
            ovf_q <= ovf_nxt;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule
